// File: rtl/data_mem_responder.sv
// Memory-side responder for the data-cache path: single outstanding load/store,
// fixed access latency, byte/half/word lanes, and completed-access counters.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_addr_mode,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [31:0]           num_reads,
  output logic [31:0]           num_writes
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Load result: pick the lane, then sign- or zero-extend; unknown modes read a word.
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [2:0]  mode,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    case (mode)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b100:  load_extend = {24'h000000, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b101:  load_extend = {16'h0000, h};
      default: load_extend = w;
    endcase
  endfunction

  // Store merge: replace only the addressed byte/half; size comes from mode[1:0].
  function automatic logic [31:0] merge_store(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [2:0]  mode,
                                              input logic [1:0]  lane);
    logic [31:0] w;
    w = old;
    case (mode)
      3'b000, 3'b100: begin
        case (lane)
          2'd0:    w[7:0]   = wd[7:0];
          2'd1:    w[15:8]  = wd[7:0];
          2'd2:    w[23:16] = wd[7:0];
          default: w[31:24] = wd[7:0];
        endcase
      end
      3'b001, 3'b101: begin
        if (lane[1]) begin
          w[31:16] = wd[15:0];
        end else begin
          w[15:0] = wd[15:0];
        end
      end
      default: w = wd;
    endcase
    merge_store = w;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      mode_q, mode_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     num_reads_q, num_reads_d;
  logic [31:0]     num_writes_q, num_writes_d;

  logic [31:0]     mem_q [MEM_WORDS];
  logic [31:0]     mem_rd_s;
  logic [31:0]     mem_wdata_s;
  logic            mem_we_s;
  logic            unused_addr_s;

  assign unused_addr_s = ^req_addr[ADDR_WIDTH-1:IW+2];
  assign mem_rd_s      = mem_q[idx_q];

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign num_reads  = num_reads_q;
  assign num_writes = num_writes_q;

  // Next-state, capture, access and counter update logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    mode_d       = mode_q;
    idx_d        = idx_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    num_reads_d  = num_reads_q;
    num_writes_d = num_writes_q;
    mem_we_s     = 1'b0;
    mem_wdata_s  = merge_store(mem_rd_s, wdata_q, mode_q, lane_q);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          mode_d  = req_addr_mode;
          idx_d   = req_addr[IW+1:2];
          lane_d  = req_addr[1:0];
          wdata_d = req_wdata;
          // LATENCY==1 loads 0 here, so the access happens on the very next edge.
          cnt_d   = CW'(LATENCY - 1);
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == {CW{1'b0}}) begin
          mem_we_s = we_q;
          rdata_d  = we_q ? 32'h0000_0000 : load_extend(mem_rd_s, mode_q, lane_q);
          state_d  = ST_RESP;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
          if (we_q) begin
            num_writes_d = num_writes_q + 32'd1;
          end else begin
            num_reads_d = num_reads_q + 32'd1;
          end
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CW{1'b0}};
      we_q         <= 1'b0;
      mode_q       <= 3'b000;
      idx_q        <= {IW{1'b0}};
      lane_q       <= 2'b00;
      wdata_q      <= 32'h0000_0000;
      rdata_q      <= 32'h0000_0000;
      num_reads_q  <= 32'h0000_0000;
      num_writes_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      num_reads_q  <= num_reads_d;
      num_writes_q <= num_writes_d;
    end
  end

  // Word array; not reset, and a store pending at reset is never committed.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[idx_q] <= mem_wdata_s;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=3, MEM_WORDS=1024).
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_addr_mode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [31:0] num_reads;
  logic [31:0] num_writes;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] M_B  = 3'b000;
  localparam logic [2:0] M_H  = 3'b001;
  localparam logic [2:0] M_W  = 3'b010;
  localparam logic [2:0] M_BU = 3'b100;
  localparam logic [2:0] M_HU = 3'b101;

  data_mem_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(1024), .LATENCY(3)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr_mode(req_addr_mode), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .num_reads(num_reads), .num_writes(num_writes)
  );

  always #5 clk = ~clk;

  // Drive one request, measure edges to resp_valid, then complete the handshake.
  task automatic do_req(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr_mode = mode; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = resp_rdata;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
    checks++; if (num_reads !== 32'h0 || num_writes !== 32'h0) begin
      errors++; $display("FAIL rst_counters got r=%h w=%h exp 0/0", num_reads, num_writes);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_word_roundtrip();
    logic [31:0] rd; int lat;
    do_req(1'b1, M_W, 32'h40, 32'hDEADBEEF, rd, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rt_store_lat got %0d exp 3", lat); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rt_store_rdata got %h exp 0", rd); end
    do_req(1'b0, M_W, 32'h40, 32'h0, rd, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rt_load_lat got %0d exp 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rt_load_rdata got %h exp deadbeef", rd); end
    checks++; if (num_writes !== 32'd1 || num_reads !== 32'd1) begin
      errors++; $display("FAIL rt_counters got r=%0d w=%0d exp 1/1", num_reads, num_writes);
    end
  endtask

  task automatic test_merge();
    logic [31:0] rd; int lat;
    do_req(1'b1, M_W, 32'h80, 32'h11223344, rd, lat);
    do_req(1'b1, M_B, 32'h82, 32'h000000AA, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mg_storeb_rdata got %h exp 0", rd); end
    do_req(1'b0, M_W, 32'h80, 32'h0, rd, lat);
    checks++; if (rd !== 32'h11AA3344) begin errors++; $display("FAIL mg_w got %h exp 11aa3344", rd); end
    do_req(1'b0, M_B, 32'h82, 32'h0, rd, lat);
    checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL mg_b got %h exp ffffffaa", rd); end
    do_req(1'b0, M_BU, 32'h82, 32'h0, rd, lat);
    checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL mg_bu got %h exp 000000aa", rd); end
    do_req(1'b0, M_H, 32'h82, 32'h0, rd, lat);
    checks++; if (rd !== 32'h000011AA) begin errors++; $display("FAIL mg_h got %h exp 000011aa", rd); end
    do_req(1'b0, M_HU, 32'h80, 32'h0, rd, lat);
    checks++; if (rd !== 32'h00003344) begin errors++; $display("FAIL mg_hu got %h exp 00003344", rd); end
    // Misaligned half store at 0x83 lands in the upper half.
    do_req(1'b1, M_H, 32'h83, 32'h1234BEEF, rd, lat);
    do_req(1'b0, M_H, 32'h82, 32'h0, rd, lat);
    checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL mg_h_neg got %h exp ffffbeef", rd); end
    do_req(1'b0, 3'b111, 32'h81, 32'h0, rd, lat);
    checks++; if (rd !== 32'hBEEF3344) begin errors++; $display("FAIL mg_undef_mode got %h exp beef3344", rd); end
    checks++; if (num_writes !== 32'd4 || num_reads !== 32'd8) begin
      errors++; $display("FAIL mg_counters got r=%0d w=%0d exp 8/4", num_reads, num_writes);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; int lat;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr_mode = M_W; req_addr = 32'h80; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL bp_lat got %0d exp 3", lat); end
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        req_valid = 1'b1; req_we = 1'b1; req_addr_mode = M_W; req_addr = 32'h80; req_wdata = 32'h0;
      end else if (i == 3) begin
        req_valid = 1'b0;
      end
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hBEEF3344) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h exp 1/beef3344", i, resp_valid, resp_rdata);
      end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d] got %b exp 0", i, req_ready); end
      checks++; if (num_reads !== 32'd8) begin errors++; $display("FAIL bp_counter[%0d] got %0d exp 8", i, num_reads); end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++; if (num_reads !== 32'd9 || num_writes !== 32'd4) begin
      errors++; $display("FAIL bp_count_after got r=%0d w=%0d exp 9/4", num_reads, num_writes);
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL bp_no_accept[%0d] got rdy=%b v=%b exp 1/0", i, req_ready, resp_valid);
      end
      @(posedge clk); #1;
    end
    do_req(1'b0, M_W, 32'h80, 32'h0, rd, lat);
    checks++; if (rd !== 32'hBEEF3344) begin errors++; $display("FAIL bp_mem_intact got %h exp beef3344", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; int lat;
    do_req(1'b1, M_W, 32'h1000, 32'h12345678, rd, lat);
    do_req(1'b0, M_W, 32'h0, 32'h0, rd, lat);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL wrap got %h exp 12345678", rd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int lat;
    do_req(1'b1, M_W, 32'h10, 32'h0, rd, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr_mode = M_W; req_addr = 32'h10; req_wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++; if (num_writes !== 32'h0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rm_async got w=%0d rdy=%b exp 0/1", num_writes, req_ready);
    end
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, M_W, 32'h10, 32'h0, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rm_not_committed got %h exp 0", rd); end
    checks++; if (num_writes !== 32'd0 || num_reads !== 32'd1) begin
      errors++; $display("FAIL rm_counters got r=%0d w=%0d exp 1/0", num_reads, num_writes);
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr_mode = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    test_reset();
    test_word_roundtrip();
    test_merge();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
